// File: rtl/me_pkg.sv
`default_nettype none
// ============================================================================
// Module   : me_pkg
// Brief    : Shared constants, FSM state encoding and pixel helper for me_engine
// Revision : 1.0
// ============================================================================
package me_pkg;

    localparam int BLK   = 4;
    localparam int WIN   = 8;
    localparam int NCAND = 25;
    localparam int SAD_W = 12;
    localparam int SRCH  = WIN - BLK + 1;

    typedef enum logic [2:0] {
        LOAD_CUR = 3'd0,
        LOAD_REF = 3'd1,
        WAIT     = 3'd2,
        COMPUTE  = 3'd3,
        DONE     = 3'd4
    } state_t;

    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/me_sad4x4.sv
`default_nettype none
// ============================================================================
// Module   : me_sad4x4
// Brief    : Combinational sum of absolute differences over a 4x4 pixel block
// Revision : 1.0
// ============================================================================
module me_sad4x4
    import me_pkg::*;
(
    input  logic [BLK*BLK*8-1:0] cur_blk,
    input  logic [BLK*BLK*8-1:0] ref_blk,
    output logic [SAD_W-1:0]     sad
);

    logic [SAD_W-1:0] w_acc;

    // Pixel (r,c) of either block sits at byte index 4*r+c.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < BLK*BLK; i++) begin
            w_acc = w_acc + {4'b0000, abs_diff(cur_blk[i*8 +: 8], ref_blk[i*8 +: 8])};
        end
    end

    assign sad = w_acc;

endmodule
`default_nettype wire

// File: rtl/me_engine.sv
`default_nettype none
// ============================================================================
// Module   : me_engine
// Brief    : Full-search 4x4 block matcher over an 8x8 window, +/-2 motion range
// Revision : 1.0
// ============================================================================
module me_engine
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      cur_in,
    input  logic [63:0]      ref_in,
    output logic             need_cur,
    output logic             need_ref,
    output logic             done,
    output logic [2:0]       mv_x,
    output logic [2:0]       mv_y,
    output logic [SAD_W-1:0] min_sad
);

    localparam logic [4:0] c_cur_last  = 5'(BLK - 1);
    localparam logic [4:0] c_ref_last  = 5'(WIN - 1);
    localparam logic [4:0] c_cand_last = 5'(NCAND - 1);
    localparam logic [2:0] c_off_last  = 3'(SRCH - 1);
    localparam logic [2:0] c_center    = 3'd2;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_cnt;
    logic [4:0]       w_cnt_nxt;
    logic [2:0]       r_dx;
    logic [2:0]       r_dy;
    logic [2:0]       w_dx_nxt;
    logic [2:0]       w_dy_nxt;
    logic             r_run;

    logic             r_need_cur_d;
    logic             r_need_ref_d;
    logic [1:0]       r_cur_row;
    logic [2:0]       r_ref_row;
    logic [7:0]       r_cur [BLK][BLK];
    logic [7:0]       r_ref [WIN][WIN];

    logic [BLK*BLK*8-1:0] w_cur_blk;
    logic [BLK*BLK*8-1:0] w_ref_blk;
    logic [SAD_W-1:0]     w_sad;

    logic             r_best_valid;
    logic [SAD_W-1:0] r_best_sad;
    logic [2:0]       r_best_dx;
    logic [2:0]       r_best_dy;
    logic             w_better;
    logic [SAD_W-1:0] w_fin_sad;
    logic [2:0]       w_fin_dx;
    logic [2:0]       w_fin_dy;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD_CUR;
            r_cnt   <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dx    <= w_dx_nxt;
            r_dy    <= w_dy_nxt;
            r_run   <= 1'b1;
        end
    end

    // The first cycle out of reset only arms r_run, so row 0 is requested
    // with r_cnt still at 0 and each request cycle carries its own row index.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;
        case (r_state)
            LOAD_CUR: begin
                if (r_run) begin
                    if (r_cnt == c_cur_last) begin
                        w_state_nxt = LOAD_REF;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 5'd1;
                    end
                end
            end
            LOAD_REF: begin
                if (r_cnt == c_ref_last) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            WAIT: begin
                w_state_nxt = COMPUTE;
                w_cnt_nxt   = '0;
                w_dx_nxt    = '0;
                w_dy_nxt    = '0;
            end
            COMPUTE: begin
                if (r_cnt == c_cand_last) begin
                    w_state_nxt = DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
                if (r_dx == c_off_last) begin
                    w_dx_nxt = '0;
                    w_dy_nxt = r_dy + 3'd1;
                end else begin
                    w_dx_nxt = r_dx + 3'd1;
                end
            end
            DONE: begin
                w_state_nxt = LOAD_CUR;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = LOAD_CUR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request bookkeeping: a word arrives one cycle after its request
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_need_cur_d <= 1'b0;
            r_need_ref_d <= 1'b0;
            r_cur_row    <= '0;
            r_ref_row    <= '0;
        end else begin
            r_need_cur_d <= need_cur;
            r_need_ref_d <= need_ref;
            r_cur_row    <= r_cnt[1:0];
            r_ref_row    <= r_cnt[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (r_need_cur_d) begin
            for (int c = 0; c < BLK; c++) begin
                r_cur[r_cur_row][c] <= cur_in[c*8 +: 8];
            end
        end
        if (r_need_ref_d) begin
            for (int c = 0; c < WIN; c++) begin
                r_ref[r_ref_row][c] <= ref_in[c*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Candidate window selection and SAD
    // ------------------------------------------------------------------
    always_comb begin
        w_cur_blk = '0;
        w_ref_blk = '0;
        for (int r = 0; r < BLK; r++) begin
            for (int c = 0; c < BLK; c++) begin
                w_cur_blk[(r*BLK + c)*8 +: 8] = r_cur[r][c];
                w_ref_blk[(r*BLK + c)*8 +: 8] = r_ref[3'(r) + r_dy][3'(c) + r_dx];
            end
        end
    end

    me_sad4x4 u_sad (
        .cur_blk (w_cur_blk),
        .ref_blk (w_ref_blk),
        .sad     (w_sad)
    );

    // Strict compare keeps the earliest raster candidate on ties.
    assign w_better  = !r_best_valid || (w_sad < r_best_sad);
    assign w_fin_sad = w_better ? w_sad : r_best_sad;
    assign w_fin_dx  = w_better ? r_dx  : r_best_dx;
    assign w_fin_dy  = w_better ? r_dy  : r_best_dy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_best_valid <= 1'b0;
            r_best_sad   <= '0;
            r_best_dx    <= '0;
            r_best_dy    <= '0;
        end else if (r_state == WAIT) begin
            r_best_valid <= 1'b0;
        end else if (r_state == COMPUTE && w_better) begin
            r_best_valid <= 1'b1;
            r_best_sad   <= w_sad;
            r_best_dx    <= r_dx;
            r_best_dy    <= r_dy;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, loaded from the next state so they line up with it
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            need_cur <= 1'b0;
            need_ref <= 1'b0;
            done     <= 1'b0;
            mv_x     <= '0;
            mv_y     <= '0;
            min_sad  <= '0;
        end else begin
            need_cur <= (w_state_nxt == LOAD_CUR);
            need_ref <= (w_state_nxt == LOAD_REF);
            done     <= (w_state_nxt == DONE);
            if (w_state_nxt == DONE) begin
                mv_x    <= w_fin_dx - c_center;
                mv_y    <= w_fin_dy - c_center;
                min_sad <= w_fin_sad;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_me_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_me_engine
// Brief    : Self-checking bench for me_engine (table vectors + random blocks)
// Revision : 1.0
// ============================================================================
module tb_me_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cur_in;
    logic [63:0] ref_in;
    logic        need_cur;
    logic        need_ref;
    logic        done;
    logic [2:0]  mv_x;
    logic [2:0]  mv_y;
    logic [11:0] min_sad;

    always #5 clk = ~clk;

    me_engine dut (
        .clk      (clk),
        .rst      (rst),
        .cur_in   (cur_in),
        .ref_in   (ref_in),
        .need_cur (need_cur),
        .need_ref (need_ref),
        .done     (done),
        .mv_x     (mv_x),
        .mv_y     (mv_y),
        .min_sad  (min_sad)
    );

    typedef struct packed {
        logic [15:0][7:0] cur;
        logic [63:0][7:0] rw;
        int               exp_x;
        int               exp_y;
        int               exp_sad;
    } vec_t;

    localparam int NVEC = 8;
    vec_t tbl [NVEC];
    vec_t extra;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [31:0] cur_words [4];
    logic [63:0] ref_words [8];
    int          cur_idx, ref_idx;
    bit          pend_cur, pend_ref;
    int          n_cur, n_ref, first_cyc, done_cyc, last_done;
    bit          overlap, hold_bad, saw_done;
    logic [2:0]  held_x, held_y;
    logic [11:0] held_sad;
    int          got_x, got_y, got_sad;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: evaluate every candidate, take the minimum, report the first
    // candidate in raster order that achieves it.
    task automatic model(inout vec_t v);
        int sads [25];
        int best, k, d;
        best = 1 << 30;
        for (int dy = 0; dy < 5; dy++)
            for (int dx = 0; dx < 5; dx++) begin
                sads[dy*5 + dx] = 0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) begin
                        d = int'(v.cur[r*4 + c]) - int'(v.rw[(r+dy)*8 + c + dx]);
                        sads[dy*5 + dx] += (d < 0) ? -d : d;
                    end
                if (sads[dy*5 + dx] < best) best = sads[dy*5 + dx];
            end
        k = 0;
        while (sads[k] != best) k++;
        v.exp_x   = (k % 5) - 2;
        v.exp_y   = (k / 5) - 2;
        v.exp_sad = best;
    endtask

    task automatic fill_random(inout vec_t v, input int hi);
        for (int i = 0; i < 16; i++) v.cur[i] = 8'($urandom_range(0, hi));
        for (int i = 0; i < 64; i++) v.rw[i]  = 8'($urandom_range(0, hi));
    endtask

    task automatic load(input vec_t v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) cur_words[r][c*8 +: 8] = v.cur[r*4 + c];
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) ref_words[r][c*8 +: 8] = v.rw[r*8 + c];
        cur_idx = 0; ref_idx = 0;
        n_cur = 0; n_ref = 0; first_cyc = -1; done_cyc = -1;
        overlap = 1'b0; hold_bad = 1'b0; saw_done = 1'b0;
    endtask

    // One clock: serve last cycle's requests, then observe this cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (pend_cur && cur_idx < 4) begin
            cur_in = cur_words[cur_idx];
            cur_idx++;
        end else begin
            cur_in = $urandom;
        end
        if (pend_ref && ref_idx < 8) begin
            ref_in = ref_words[ref_idx];
            ref_idx++;
        end else begin
            ref_in = {$urandom, $urandom};
        end
        pend_cur = need_cur;
        pend_ref = need_ref;
        if (need_cur && need_ref) overlap = 1'b1;
        if (need_cur) begin
            n_cur++;
            if (first_cyc < 0) first_cyc = cyc;
        end
        if (need_ref) n_ref++;
        if (done) begin
            saw_done = 1'b1;
            held_x = mv_x; held_y = mv_y; held_sad = min_sad;
        end else if (mv_x != held_x || mv_y != held_y || min_sad != held_sad) begin
            hold_bad = 1'b1;
        end
    endtask

    task automatic run_block(input vec_t v, input bit b2b);
        load(v);
        for (int k = 0; k < 80 && done_cyc < 0; k++) begin
            step();
            if (done) begin
                done_cyc = cyc;
                got_x    = int'($signed(mv_x));
                got_y    = int'($signed(mv_y));
                got_sad  = int'(min_sad);
            end
        end
        chk("done_seen", int'(done_cyc >= 0), 1);
        chk("done_latency", done_cyc - first_cyc, 38);
        chk("need_cur_count", n_cur, 4);
        chk("need_ref_count", n_ref, 8);
        chk("need_overlap", int'(overlap), 0);
        chk("outputs_held", int'(hold_bad), 0);
        chk("mv_x", got_x, v.exp_x);
        chk("mv_y", got_y, v.exp_y);
        chk("min_sad", got_sad, v.exp_sad);
        if (b2b) chk("done_period", done_cyc - last_done, 39);
        last_done = done_cyc;
    endtask

    task automatic check_zero_outputs(input string nm);
        chk(nm, int'({need_cur, need_ref, done, mv_x, mv_y, min_sad}), 0);
    endtask

    initial begin
        rst = 1'b1; cur_in = '0; ref_in = '0;
        pend_cur = 1'b0; pend_ref = 1'b0;
        held_x = '0; held_y = '0; held_sad = '0; last_done = 0;

        // Cur block copied into the window at (2,2): zero motion.
        fill_random(tbl[0], 255);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) tbl[0].rw[(r+2)*8 + c + 2] = tbl[0].cur[r*4 + c];
        tbl[0].exp_x = 0; tbl[0].exp_y = 0; tbl[0].exp_sad = 0;
        // Copy at dy=4, dx=0.
        fill_random(tbl[1], 255);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) tbl[1].rw[(r+4)*8 + c] = tbl[1].cur[r*4 + c];
        tbl[1].exp_x = -2; tbl[1].exp_y = 2; tbl[1].exp_sad = 0;
        // All candidates tie at the maximum SAD.
        tbl[2].cur = '0; tbl[2].rw = '1;
        tbl[2].exp_x = -2; tbl[2].exp_y = -2; tbl[2].exp_sad = 4080;
        for (int i = 3; i < NVEC; i++) begin
            fill_random(tbl[i], (i < 5) ? 3 : 255);
            model(tbl[i]);
        end

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset_outputs");
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) run_block(tbl[i], i > 0);

        // Abort a block in the middle of COMPUTE.
        fill_random(extra, 255);
        load(extra);
        for (int k = 0; k < 80; k++) begin
            step();
            if (first_cyc >= 0 && cyc - first_cyc == 20) break;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        check_zero_outputs("abort_outputs");
        chk("abort_no_done", int'(saw_done), 0);
        pend_cur = 1'b0; pend_ref = 1'b0;
        held_x = '0; held_y = '0; held_sad = '0;
        rst = 1'b0;

        fill_random(extra, 255);
        model(extra);
        run_block(extra, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
